mul_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one slowmpy multiplier between NREQ requesters, such as the frame-rate edge-init engine and a future shading/colour unit.
- Accepts one multiply request at a time, launches it on the multiplier, and waits for the product.
- Returns the full product to the granted requester with a one-cycle valid pulse.
- A watchdog returns an error response if the multiplier never signals done.

---
 rtl/mul_arbiter_pkg.sv | 24 ++
 rtl/mul_arbiter_if.sv | 35 +++
 rtl/mul_arbiter_rr_pick.sv | 29 ++
 rtl/mul_arbiter.sv | 171 +++++++++++++++++
 tb/tb_mul_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mul_arbiter_pkg.sv
// Shared types and defaults for the multiplier arbiter slice.
package mul_arbiter_pkg;

    // Arbiter sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } arb_state_e;

    localparam int W_OPER      = 20;
    localparam int W_PROD      = 40;
    localparam int TIMEOUT_DEF = 63;

    // Modulo-n add for indices already below n (one subtraction is enough).
    function automatic logic [31:0] wrap_add(input logic [31:0] base,
                                             input logic [31:0] off,
                                             input logic [31:0] n);
        logic [31:0] sum_v;
        sum_v = base + off;
        return (sum_v >= n) ? (sum_v - n) : sum_v;
    endfunction

endpackage

// File: rtl/mul_arbiter_if.sv
// Requester and multiplier bus of the shared-multiplier arbiter.
interface mul_arbiter_if
    import mul_arbiter_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int W    = W_OPER,
    parameter int PW   = W_PROD
);
    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   rsp_valid;
    logic [PW-1:0]     rsp_p;
    logic              rsp_err;
    logic              busy;
    logic              mul_start;
    logic [W-1:0]      mul_a;
    logic [W-1:0]      mul_b;
    logic              mul_busy;
    logic              mul_done;
    logic [PW-1:0]     mul_result;

    // Arbiter side
    modport master (
        input  req, req_a, req_b, mul_busy, mul_done, mul_result,
        output gnt, rsp_valid, rsp_p, rsp_err, busy, mul_start, mul_a, mul_b
    );

    // Requesters plus multiplier side
    modport slave (
        output req, req_a, req_b, mul_busy, mul_done, mul_result,
        input  gnt, rsp_valid, rsp_p, rsp_err, busy, mul_start, mul_a, mul_b
    );
endinterface

// File: rtl/mul_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: first set request at or
// above rr_ptr, wrapping modulo NREQ.
module rr_pick
    import mul_arbiter_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int PTRW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PTRW-1:0] rr_ptr,
    output logic            valid,
    output logic [PTRW-1:0] winner
);

    logic [PTRW-1:0] idx_s;

    // Scan from the farthest offset down so the nearest hit is written last
    always_comb begin
        valid  = 1'b0;
        winner = '0;
        idx_s  = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            idx_s  = PTRW'(wrap_add(32'(rr_ptr), 32'(i), 32'(NREQ)));
            winner = req[idx_s] ? idx_s : winner;
            valid  = valid | req[idx_s];
        end
    end

endmodule

// File: rtl/mul_arbiter.sv
// Round-robin arbiter/sequencer sharing one slowmpy multiplier between
// NREQ requesters, with a watchdog that answers with an error response
// when the multiplier never reports done.
module mul_arbiter
    import mul_arbiter_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int W       = W_OPER,
    parameter int PW      = W_PROD,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic          clk,
    input  logic          reset,
    mul_arbiter_if.master bus
);

    localparam int PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW   = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT);

    arb_state_e      state_r, state_s;
    logic [PTRW-1:0] rr_ptr_r, rr_ptr_s;
    logic [PTRW-1:0] winner_r, winner_s;
    logic [CW-1:0]   cnt_r, cnt_s;
    logic [NREQ-1:0] gnt_r, gnt_s;
    logic            mul_start_r, mul_start_s;
    logic [W-1:0]    mul_a_r, mul_a_s;
    logic [W-1:0]    mul_b_r, mul_b_s;
    logic [NREQ-1:0] rsp_valid_r, rsp_valid_s;
    logic [PW-1:0]   rsp_p_r, rsp_p_s;
    logic            rsp_err_r, rsp_err_s;
    logic            busy_r, busy_s;

    logic            pick_valid_s;
    logic [PTRW-1:0] pick_idx_s;
    logic [W-1:0]    sel_a_s, sel_b_s;

    function automatic logic [NREQ-1:0] to_onehot(input logic [PTRW-1:0] idx);
        logic [NREQ-1:0] v;
        for (int k = 0; k < NREQ; k++) begin
            v[k] = (idx == PTRW'(k));
        end
        return v;
    endfunction

    rr_pick #(
        .NREQ (NREQ),
        .PTRW (PTRW)
    ) u_pick (
        .req    (bus.req),
        .rr_ptr (rr_ptr_r),
        .valid  (pick_valid_s),
        .winner (pick_idx_s)
    );

    // Operand mux: slice of the candidate winner, captured only at grant
    always_comb begin
        sel_a_s = '0;
        sel_b_s = '0;
        for (int k = 0; k < NREQ; k++) begin
            sel_a_s = (pick_idx_s == PTRW'(k)) ? bus.req_a[k*W +: W] : sel_a_s;
            sel_b_s = (pick_idx_s == PTRW'(k)) ? bus.req_b[k*W +: W] : sel_b_s;
        end
    end

    // Next state plus next values of every registered output
    always_comb begin
        state_s     = state_r;
        rr_ptr_s    = rr_ptr_r;
        winner_s    = winner_r;
        cnt_s       = cnt_r;
        gnt_s       = '0;
        mul_start_s = 1'b0;
        mul_a_s     = mul_a_r;
        mul_b_s     = mul_b_r;
        rsp_valid_s = '0;
        rsp_p_s     = rsp_p_r;
        rsp_err_s   = rsp_err_r;
        busy_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                // A busy multiplier defers arbitration; requests simply wait
                if (pick_valid_s && !bus.mul_busy) begin
                    state_s     = ST_WAIT;
                    winner_s    = pick_idx_s;
                    gnt_s       = to_onehot(pick_idx_s);
                    mul_start_s = 1'b1;
                    mul_a_s     = sel_a_s;
                    mul_b_s     = sel_b_s;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                // Done takes precedence over a simultaneous timeout
                if (bus.mul_done) begin
                    state_s     = ST_RESP;
                    rsp_p_s     = bus.mul_result;
                    rsp_err_s   = 1'b0;
                    rsp_valid_s = to_onehot(winner_r);
                end else if (cnt_r == TIMEOUT_C) begin
                    state_s     = ST_RESP;
                    rsp_p_s     = '0;
                    rsp_err_s   = 1'b1;
                    rsp_valid_s = to_onehot(winner_r);
                end else begin
                    cnt_s = cnt_r + CW'(1);
                end
            end
            ST_RESP: begin
                // Response pulse is on the wire this cycle; rotate priority
                state_s  = ST_IDLE;
                rr_ptr_s = PTRW'(wrap_add(32'(winner_r), 32'd1, 32'(NREQ)));
                cnt_s    = '0;
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = '0;
            end
        endcase
        busy_s = (state_s != ST_IDLE);
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath, watchdog and output registers; reset abandons any job
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr_r    <= '0;
            winner_r    <= '0;
            cnt_r       <= '0;
            gnt_r       <= '0;
            mul_start_r <= 1'b0;
            mul_a_r     <= '0;
            mul_b_r     <= '0;
            rsp_valid_r <= '0;
            rsp_p_r     <= '0;
            rsp_err_r   <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            rr_ptr_r    <= rr_ptr_s;
            winner_r    <= winner_s;
            cnt_r       <= cnt_s;
            gnt_r       <= gnt_s;
            mul_start_r <= mul_start_s;
            mul_a_r     <= mul_a_s;
            mul_b_r     <= mul_b_s;
            rsp_valid_r <= rsp_valid_s;
            rsp_p_r     <= rsp_p_s;
            rsp_err_r   <= rsp_err_s;
            busy_r      <= busy_s;
        end
    end

    assign bus.gnt       = gnt_r;
    assign bus.mul_start = mul_start_r;
    assign bus.mul_a     = mul_a_r;
    assign bus.mul_b     = mul_b_r;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_p     = rsp_p_r;
    assign bus.rsp_err   = rsp_err_r;
    assign bus.busy      = busy_r;

endmodule

// File: tb/tb_mul_arbiter.sv
// Scoreboard bench for mul_arbiter with a behavioural slowmpy model.
module tb_mul_arbiter;
    import mul_arbiter_pkg::*;

    localparam int NREQ    = 2;
    localparam int W       = 20;
    localparam int PW      = 40;
    localparam int TIMEOUT = 63;
    localparam int LAT     = 19;

    typedef struct {
        int     who;
        longint p;
        logic   err;
    } exp_t;

    logic clk;
    logic reset;

    mul_arbiter_if #(.NREQ(NREQ), .W(W), .PW(PW)) bus ();

    mul_arbiter #(
        .NREQ    (NREQ),
        .W       (W),
        .PW      (PW),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int      n_checks  = 0;
    int      n_pass    = 0;
    int      rsp_count = 0;
    longint  cyc       = 0;
    exp_t    exp_q[$];
    int      gnt_q[$];
    longint  gnt_cyc_q[$];

    logic          m_busy, m_done, ext_busy, spur_done, never_done;
    logic [PW-1:0] m_p;

    assign bus.mul_busy   = m_busy | ext_busy;
    assign bus.mul_done   = m_done | spur_done;
    assign bus.mul_result = spur_done ? PW'(40'h12345) : m_p;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input int who, input longint p, input logic err);
        exp_t e;
        e.who = who;
        e.p   = p;
        e.err = err;
        exp_q.push_back(e);
    endtask

    task automatic set_ops(input int k, input longint a, input longint b);
        bus.req_a[k*W +: W] = W'(a);
        bus.req_b[k*W +: W] = W'(b);
    endtask

    task automatic wait_count(input int target, input string tag);
        for (int i = 0; i < 400 && rsp_count < target; i++) begin
            @(negedge clk);
        end
        check_eq(tag, 64'(rsp_count), 64'(target));
    endtask

    function automatic int onehot_idx(input logic [NREQ-1:0] v);
        for (int i = 0; i < NREQ; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    function automatic int gnt_at(input int i);
        if (i < gnt_q.size()) return gnt_q[i];
        return -1;
    endfunction

    function automatic longint cyc_at(input int i);
        if (i < gnt_cyc_q.size()) return gnt_cyc_q[i];
        return -1;
    endfunction

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle counter
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Multiplier model: done appears LAT cycles after the start cycle
    initial begin
        int cnt_v;
        logic signed [W-1:0] a_v, b_v;
        m_busy = 1'b0; m_done = 1'b0; m_p = '0;
        cnt_v = 0; a_v = '0; b_v = '0;
        forever begin
            @(negedge clk);
            m_done = 1'b0;
            if (reset) begin
                cnt_v  = 0;
                m_busy = 1'b0;
            end else if (cnt_v > 0) begin
                cnt_v--;
                if (cnt_v == 0) begin
                    m_done = 1'b1;
                    m_busy = 1'b0;
                    m_p    = PW'(longint'(a_v) * longint'(b_v));
                end
            end else if (bus.mul_start && !never_done) begin
                a_v    = bus.mul_a;
                b_v    = bus.mul_b;
                cnt_v  = LAT;
                m_busy = 1'b1;
            end
        end
    end

    // Monitor: grant log and scoreboard compare on every response
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && bus.gnt != '0) begin
                gnt_q.push_back(onehot_idx(bus.gnt));
                gnt_cyc_q.push_back(cyc);
                check_eq("gnt_onehot", 64'($onehot(bus.gnt)), 64'd1);
            end
            if (!reset && bus.rsp_valid != '0) begin
                rsp_count++;
                if (exp_q.size() == 0) begin
                    check_eq("rsp_unexpected", 64'(bus.rsp_valid), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("rsp_who", 64'(bus.rsp_valid), 64'(1) << e.who);
                    check_eq("rsp_p", 64'($signed(bus.rsp_p)), 64'(e.p));
                    check_eq("rsp_err", 64'(bus.rsp_err), 64'(e.err));
                end
            end
        end
    end

    // Global time limit
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "time limit");
    end

    // Main stimulus
    initial begin
        longint g_cyc;
        int     base;
        int     g0;
        int     ng;
        logic   bad;

        reset = 1'b1;
        bus.req = '0; bus.req_a = '0; bus.req_b = '0;
        ext_busy = 1'b0; spur_done = 1'b0; never_done = 1'b0;
        #1;
        check_eq("rst_gnt", 64'(bus.gnt), 64'd0);
        check_eq("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check_eq("rst_rsp_p", 64'(bus.rsp_p), 64'd0);
        check_eq("rst_rsp_err", 64'(bus.rsp_err), 64'd0);
        check_eq("rst_busy", 64'(bus.busy), 64'd0);
        check_eq("rst_mul_start", 64'(bus.mul_start), 64'd0);
        check_eq("rst_mul_ab", 64'({bus.mul_a, bus.mul_b}), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Single request from requester 0
        set_ops(0, 250, -225);
        push_exp(0, -56250, 1'b0);
        bus.req = 2'b01;
        @(negedge clk);
        g_cyc = cyc;
        check_eq("t1_gnt", 64'(bus.gnt), 64'b01);
        check_eq("t1_mul_start", 64'(bus.mul_start), 64'd1);
        check_eq("t1_mul_a", 64'($signed(bus.mul_a)), 64'(250));
        check_eq("t1_mul_b", 64'($signed(bus.mul_b)), 64'(-225));
        check_eq("t1_busy", 64'(bus.busy), 64'd1);
        bus.req = 2'b00;
        @(negedge clk);
        check_eq("t1_pulse_width", 64'({bus.gnt, bus.mul_start}), 64'd0);
        for (int i = 0; i < 200 && bus.rsp_valid == '0; i++) begin
            @(negedge clk);
        end
        check_eq("t1_latency", 64'(cyc - g_cyc), 64'(LAT + 1));
        @(negedge clk);
        check_eq("t1_rsp_hold", 64'($signed(bus.rsp_p)), 64'(-56250));
        check_eq("t1_idle", 64'({bus.busy, bus.rsp_valid}), 64'd0);

        // Reset in the middle of WAIT abandons the job
        base = rsp_count;
        set_ops(1, 11, 13);
        bus.req = 2'b10;
        @(negedge clk);
        check_eq("rw_gnt", 64'(bus.gnt), 64'b10);
        bus.req = 2'b00;
        repeat (5) @(negedge clk);
        check_eq("rw_busy_before", 64'(bus.busy), 64'd1);
        #2 reset = 1'b1;
        #1;
        check_eq("rw_busy", 64'(bus.busy), 64'd0);
        check_eq("rw_rsp_p", 64'(bus.rsp_p), 64'd0);
        check_eq("rw_mul_ab", 64'({bus.mul_a, bus.mul_b}), 64'd0);
        check_eq("rw_out_bits", 64'({bus.gnt, bus.rsp_valid, bus.mul_start, bus.rsp_err}), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        check_eq("rw_no_rsp", 64'(rsp_count), 64'(base));

        // Simultaneous requests: rr_ptr is back at 0, so requester 0 first
        base = rsp_count;
        g0   = gnt_q.size();
        set_ops(0, 3, 4);
        set_ops(1, -7, 5);
        push_exp(0, 12, 1'b0);
        push_exp(1, -35, 1'b0);
        bus.req = 2'b11;
        for (int i = 0; i < 200 && rsp_count < base + 2; i++) begin
            @(negedge clk);
            if (bus.gnt[0]) bus.req[0] = 1'b0;
            if (bus.gnt[1]) bus.req[1] = 1'b0;
        end
        check_eq("sim_rsps", 64'(rsp_count), 64'(base + 2));
        check_eq("sim_first", 64'(gnt_at(g0)), 64'(0));
        check_eq("sim_second", 64'(gnt_at(g0 + 1)), 64'(1));

        // Fairness with both held, extreme operands
        base = rsp_count;
        g0   = gnt_q.size();
        ng   = 0;
        set_ops(0, -524288, -524288);
        set_ops(1, 524287, -524288);
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) push_exp(0, 64'sd274877906944, 1'b0);
            else            push_exp(1, -64'sd274877382656, 1'b0);
        end
        bus.req = 2'b11;
        for (int i = 0; i < 400 && rsp_count < base + 6; i++) begin
            @(negedge clk);
            if (bus.gnt != '0) begin
                ng++;
                if (ng == 6) bus.req = 2'b00;
            end
        end
        check_eq("fair_rsps", 64'(rsp_count), 64'(base + 6));
        for (int i = 0; i < 6; i++) begin
            check_eq("fair_order", 64'(gnt_at(g0 + i)), 64'(i % 2));
        end
        for (int i = 1; i < 6; i++) begin
            check_eq("fair_spacing", 64'(cyc_at(g0 + i) - cyc_at(g0 + i - 1)), 64'(LAT + 3));
        end

        // External mul_busy holds off the grant
        base = rsp_count;
        ext_busy = 1'b1;
        set_ops(1, -3, -9);
        push_exp(1, 27, 1'b0);
        bus.req = 2'b10;
        bad = 1'b0;
        repeat (10) begin
            @(negedge clk);
            bad = bad | (bus.gnt != '0) | bus.mul_start;
        end
        check_eq("bh_no_gnt", 64'(bad), 64'd0);
        ext_busy = 1'b0;
        @(negedge clk);
        check_eq("bh_gnt", 64'(bus.gnt), 64'b10);
        bus.req = 2'b00;
        wait_count(base + 1, "bh_rsps");

        // Watchdog: the multiplier never finishes
        @(negedge clk);
        base = rsp_count;
        never_done = 1'b1;
        set_ops(0, 5, 6);
        push_exp(0, 0, 1'b1);
        bus.req = 2'b01;
        @(negedge clk);
        g_cyc = cyc;
        check_eq("wd_gnt", 64'(bus.gnt), 64'b01);
        bus.req = 2'b00;
        for (int i = 0; i < 200 && bus.rsp_valid == '0; i++) begin
            @(negedge clk);
        end
        check_eq("wd_latency", 64'(cyc - g_cyc), 64'(TIMEOUT + 1));
        @(negedge clk);
        never_done = 1'b0;
        set_ops(1, 100, -100);
        push_exp(1, -10000, 1'b0);
        bus.req = 2'b10;
        @(negedge clk);
        check_eq("wd_next_gnt", 64'(bus.gnt), 64'b10);
        bus.req = 2'b00;
        wait_count(base + 2, "wd_rsps");

        // Spurious done outside WAIT is ignored
        spur_done = 1'b1;
        repeat (3) @(negedge clk);
        spur_done = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("spur_rsp_p", 64'($signed(bus.rsp_p)), 64'(-10000));
        check_eq("spur_busy", 64'(bus.busy), 64'd0);
        check_eq("spur_rsps", 64'(rsp_count), 64'(base + 2));

        check_eq("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
